// File: rtl/seq_rca.sv
// seq_rca: sequential ripple-carry adder/subtractor.
// Each clock cycle it adds one CHUNK-bit slice, starting with the least significant slice.
// A result is ready NCHUNK cycles after the operands are accepted.
// Parameters: WIDTH (operand/sum width), CHUNK (bits per cycle); WIDTH must be a multiple of CHUNK.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   start  request, accepted when not busy (IDLE or DONE)
//   i0/i1  operands A/B, sampled on the accepting edge
//   cin    carry-in for add (ignored for subtract)
//   sub    1 = A - B, 0 = A + B + cin
//   busy   high while slices are being added
//   done   one-cycle result-valid pulse
//   o      sum/difference; cout = carry out of MSB (1 = no borrow); ovf = signed overflow
module seq_rca #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic             carry_q;  // carry between slices
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sl_sum;
  logic             last_sl;
  logic             msb_cin;
  logic [WIDTH-1:0] o_next;

  // Current slice add; the carry into the MSB is recovered from the top sum bit
  always_comb begin
    a_sl    = CHUNK'(a_q >> (idx * CHUNK));
    b_sl    = CHUNK'(b_q >> (idx * CHUNK));
    sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry_q);
    last_sl = (idx == IDX_W'(NCHUNK - 1));
    msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sl_sum[CHUNK-1];
    o_next  = o | (WIDTH'(sl_sum[CHUNK-1:0]) << (idx * CHUNK));
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      o       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= i0;
            b_q     <= sub ? ~i1 : i1;
            carry_q <= sub ? 1'b1 : cin;
            idx     <= '0;
            o       <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          o       <= o_next;
          carry_q <= sl_sum[CHUNK];
          idx     <= idx + IDX_W'(1);
          if (last_sl) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= sl_sum[CHUNK];
            ovf   <= msb_cin ^ sl_sum[CHUNK];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_rca.sv
module tb_seq_rca;

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start1;
  logic [7:0] i0, i1;
  logic       cin, sub;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] o4;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] o1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_rca #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .i0(i0), .i1(i1), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .o(o4), .cout(cout4), .ovf(ovf4)
  );

  seq_rca #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .i0(i0), .i1(i1), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .o(o1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       s;
    logic [7:0] exp_o;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {ovf, cout, o}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    int bb, ce, full, low, c7, co;
    bb   = s ? (255 - int'(b)) : int'(b);
    ce   = s ? 1 : int'(c);
    full = int'(a) + bb + ce;
    low  = (int'(a) % 128) + (bb % 128) + ce;
    c7   = (low / 128) % 2;
    co   = (full / 256) % 2;
    model = {1'((c7 + co) % 2), 1'(co), 8'(full % 256)};
  endfunction

  // One operation on the selected DUT (sel=1 -> CHUNK=1 instance)
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s,
                        output logic [7:0] ro, output logic rc, output logic rv,
                        output int lat);
    @(negedge clk);
    i0 = a; i1 = b; cin = c; sub = s;
    if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    lat = 0;
    while (!((sel == 1) ? done1 : done4) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ro = (sel == 1) ? o1 : o4;
    rc = (sel == 1) ? cout1 : cout4;
    rv = (sel == 1) ? ovf1 : ovf4;
  endtask

  logic [7:0] ro;
  logic       rc, rv;
  int         lat;
  logic [9:0] m;
  logic [7:0] ra, rb;
  logic       rcin, rsub;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h0A, 8'h05, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};

    // Reset with start asserted: start must be discarded
    reset = 1'b1; start4 = 1'b1; start1 = 1'b1;
    i0 = 8'h12; i1 = 8'h34; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_o", o4, 0);
    check("reset_cout", cout4, 0);
    check("reset_ovf", ovf4, 0);
    @(negedge clk);
    reset = 1'b0; start4 = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle_busy", busy4, 0);
    check("post_reset_idle_done", done4, 0);

    // Directed table
    for (int k = 0; k < 8; k++) begin
      run_op(0, vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].s, ro, rc, rv, lat);
      check($sformatf("vec%0d_latency", k), lat, 2);
      check($sformatf("vec%0d_o", k), ro, vecs[k].exp_o);
      check($sformatf("vec%0d_cout", k), rc, vecs[k].exp_cout);
      check($sformatf("vec%0d_ovf", k), rv, vecs[k].exp_ovf);
    end

    // Done lasts one cycle, then IDLE with results held
    @(posedge clk); #1;
    check("done_pulse_width", done4, 0);
    check("idle_busy", busy4, 0);
    check("hold_o", o4, 8'h10);
    repeat (3) @(posedge clk);
    #1;
    check("hold_o_later", o4, 8'h10);

    // Busy asserted right after acceptance
    @(negedge clk);
    i0 = 8'h0F; i1 = 8'h01; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", busy4, 1);
    check("done_after_accept", done4, 0);
    // Start with new operands during RUN is ignored
    start4 = 1'b1; i0 = 8'h33; i1 = 8'h44; sub = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("run_busy", busy4, 1);
    check("run_done_low", done4, 0);
    @(posedge clk); #1;
    check("ignore_start_done", done4, 1);
    check("ignore_start_busy", busy4, 0);
    check("ignore_start_o", o4, 8'h10);
    check("ignore_start_cout", cout4, 0);
    @(posedge clk); #1;
    check("ignore_start_no_reaccept", busy4, 0);

    // Reset at T0+1 aborts with no done pulse
    @(negedge clk);
    i0 = 8'hFF; i1 = 8'h01; cin = 1'b1; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy4, 0);
    check("abort_o", o4, 0);
    check("abort_done", done4, 0);
    begin
      int seen = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (done4) seen++;
      end
      check("abort_no_done", seen, 0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    i0 = 8'h0F; i1 = 8'h01; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    i0 = 8'h05; i1 = 8'h07; sub = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_first_done", done4, 1);
    check("b2b_first_o", o4, 8'h10);
    @(posedge clk); #1;
    check("b2b_reaccept_busy", busy4, 1);
    check("b2b_reaccept_done", done4, 0);
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_second_done", done4, 1);
    check("b2b_second_o", o4, 8'hFE);
    check("b2b_second_cout", cout4, 0);

    // CHUNK=1 instance
    run_op(1, 8'hAA, 8'h55, 1'b0, 1'b0, ro, rc, rv, lat);
    check("c1_latency", lat, 8);
    check("c1_o", ro, 8'hFF);
    check("c1_cout", rc, 0);
    check("c1_ovf", rv, 0);

    // Randomized against the reference model
    for (int k = 0; k < 150; k++) begin
      int sel;
      sel  = (k % 5 == 4) ? 1 : 0;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      m = model(ra, rb, rcin, rsub);
      run_op(sel, ra, rb, rcin, rsub, ro, rc, rv, lat);
      check($sformatf("rnd%0d_lat", k), lat, (sel == 1) ? 8 : 2);
      check($sformatf("rnd%0d_o a=%0h b=%0h c=%0d s=%0d", k, ra, rb, rcin, rsub), ro, m[7:0]);
      check($sformatf("rnd%0d_cout", k), rc, m[8]);
      check($sformatf("rnd%0d_ovf", k), rv, m[9]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_rca.md
SEQ_RCA -- requirements
Module: seq_rca

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled on a rising edge when the block is not busy.
REQ-006 i0  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-007 i1  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-008 cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 sub  input  1  0 = add, 1 = subtract (A - B); sampled only on the accepting edge.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse marking valid results.
REQ-012 o  output  WIDTH  sum or difference.
REQ-013 cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE.
REQ-016 Acceptance: in IDLE or DONE, start=1 at edge T0 SHALL latch i0, i1 (inverted if sub=1), and an effective carry-in (sub ? 1 : cin); it SHALL clear the chunk index and the result register, move to RUN, and assert busy.
REQ-017 RUN: at each edge T0+1 .. T0+NCHUNK, the block SHALL add one CHUNK-bit slice, LSB slice first, using the carry stored from the previous slice, and write the slice result into o.
REQ-018 At edge T0+NCHUNK the state SHALL become DONE: done=1 and busy=0 for exactly one cycle, and o, cout and ovf SHALL be valid.
REQ-019 Latency: done SHALL be observed high exactly NCHUNK edges after the accepting edge.
REQ-020 DONE with start=0 SHALL return to IDLE on the next edge, with done deasserting.
REQ-021 o, cout and ovf SHALL hold their last values until the next accepting edge.
REQ-022 While in RUN, start and every operand input SHALL be ignored; the latched operands SHALL NOT change.
REQ-023 Arithmetic: {cout, o} = A + B' + c_eff, modulo 2^(WIDTH+1), where B' = sub ? ~B : B.
REQ-024 ovf SHALL equal (carry into bit WIDTH-1) XOR cout.
REQ-025 CHUNK = WIDTH (NCHUNK = 1) SHALL be legal: done asserts one edge after acceptance.
REQ-026 start held high continuously SHALL cause back-to-back operations, with a new acceptance on each DONE cycle.

Reset
REQ-027 reset=1 at an edge SHALL force state IDLE, busy=0, done=0, o=0, cout=0, ovf=0, and chunk index 0.
REQ-028 Reset SHALL take priority over start, and reset during RUN SHALL abort the operation with no done pulse.
REQ-029 start present in the same cycle as reset SHALL be discarded.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-030 Add 0x0F + 0x01, cin=0 -> o=0x10, cout=0, ovf=0; done high exactly 2 edges after the start edge, for one cycle.
REQ-031 Add 0xFF + 0x01, cin=1 -> o=0x01, cout=1, ovf=0.
REQ-032 Add 0x7F + 0x01, cin=0 -> o=0x80, cout=0, ovf=1.
REQ-033 Subtract 0x05 - 0x07, with cin=1 (ignored) -> o=0xFE, cout=0 (borrow), ovf=0.
REQ-034 start pulsed with new operands during RUN -> ignored, and the original result is delivered.
REQ-035 reset asserted at edge T0+1 -> busy=0 and o=0 on the next cycle, with no done pulse.
REQ-036 With CHUNK=1, 0xAA + 0x55 -> o=0xFF after exactly 8 edges, cout=0, ovf=0.
